ladybird_gpio_irq: RTL and testbench

Parametrised GPIO peripheral on the ladybird bus with banked inputs and outputs. Each input bit passes through a synchroniser and a per-bit debounce counter. Configurable rising and falling edge detection latches events into write-1-to-clear status registers, and one level interrupt is produced per input bank. Output banks support atomic set, clear and toggle writes.

---
 rtl/ladybird_gpio_irq.sv | 204 ++++++++++++++++++++
 tb/tb_ladybird_gpio_irq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_gpio_irq.sv
// ladybird_gpio_irq
//   GPIO peripheral on the ladybird bus. Input pins are synchronised,
//   debounced per bit, and edge-detected into write-1-to-clear status
//   registers; each input bank drives one level interrupt. Output banks
//   support plain, set, clear and toggle writes.
//
// Ports
//   clk, rst      : single clock, synchronous active-high reset
//   req/addr/wstrb/wdata -> rdata/gnt/rdgnt : ladybird bus secondary side
//   GPIO_I        : raw asynchronous pins, bank i = [(i+1)*WIDTH-1 : i*WIDTH]
//   GPIO_O        : output registers
//   irq           : per input bank, high while any STATUS bit is set
module ladybird_gpio_irq #(
  parameter int WIDTH           = 8,
  parameter int N_IN            = 2,
  parameter int N_OUT           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH*N_OUT-1:0] OUT_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [31:0]            addr,
  input  logic [3:0]             wstrb,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   gnt,
  output logic                   rdgnt,
  input  logic [WIDTH*N_IN-1:0]  GPIO_I,
  output logic [WIDTH*N_OUT-1:0] GPIO_O,
  output logic [N_IN-1:0]        irq
);

  localparam int NB = WIDTH * N_IN;
  // 0 and 1 both mean "accept on the first differing cycle"
  localparam int DC = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DC - 1);

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wfield;
  logic             unused_bits;

  assign wr          = req & (|wstrb);
  assign rd          = req & ~(|wstrb);
  assign wfield      = wdata[WIDTH-1:0];
  assign gnt         = 1'b1;
  assign rdgnt       = rd;
  assign unused_bits = ^{addr[31:8], addr[1:0], wdata};

  // Bank decode: input banks occupy 0x00-0x7F in 0x20 steps, output banks
  // start at 0x80 in 0x10 steps.
  logic [N_IN-1:0]  in_hit;
  logic [N_OUT-1:0] out_hit;

  // Address decode per bank
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      in_hit[i] = (addr[7:5] == 3'(i));
    end
    for (int j = 0; j < N_OUT; j++) begin
      out_hit[j] = addr[7] && (addr[6:4] == 3'(j));
    end
  end

  // Synchroniser chain
  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] s;

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= GPIO_I;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce state
  logic [NB-1:0] d;
  logic [NB-1:0] d_next;
  logic [CW-1:0] cnt      [NB];
  logic [CW-1:0] cnt_next [NB];

  // Debounce next-state: a new level is accepted after DC consecutive
  // differing cycles; any return to the stable level restarts the count.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      d_next[b]   = d[b];
      cnt_next[b] = '0;
      if (s[b] == d[b]) begin
        cnt_next[b] = '0;
      end else if (cnt[b] == CNT_LAST) begin
        d_next[b]   = s[b];
        cnt_next[b] = '0;
      end else begin
        cnt_next[b] = cnt[b] + CW'(1);
      end
    end
  end

  // Debounce registers
  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
      for (int b = 0; b < NB; b++) cnt[b] <= '0;
    end else begin
      d <= d_next;
      for (int b = 0; b < NB; b++) cnt[b] <= cnt_next[b];
    end
  end

  // Event and status logic
  logic [NB-1:0]                rise;
  logic [NB-1:0]                fall;
  logic [N_IN-1:0][WIDTH-1:0]   status;
  logic [N_IN-1:0][WIDTH-1:0]   status_next;
  logic [N_IN-1:0][WIDTH-1:0]   rise_en;
  logic [N_IN-1:0][WIDTH-1:0]   fall_en;
  logic [N_IN-1:0][WIDTH-1:0]   w1c;

  assign rise = d_next & ~d;
  assign fall = ~d_next & d;

  // Status next-state: new events are ORed after the clear so they win
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w1c[i] = (wr && in_hit[i] && addr[4:2] == 3'd1) ? wfield : '0;
    end
    status_next = (status & ~w1c) | (rise & rise_en) | (fall & fall_en);
  end

  // Status, enable and interrupt registers; irq tracks the status update
  always_ff @(posedge clk) begin
    if (rst) begin
      status  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      irq     <= '0;
    end else begin
      status <= status_next;
      for (int i = 0; i < N_IN; i++) begin
        irq[i] <= |status_next[i];
        if (wr && in_hit[i] && addr[4:2] == 3'd2) rise_en[i] <= wfield;
        if (wr && in_hit[i] && addr[4:2] == 3'd3) fall_en[i] <= wfield;
      end
    end
  end

  // Output registers
  logic [N_OUT-1:0][WIDTH-1:0] out_q;

  // Output bank writes: plain, set, clear, toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= OUT_RESET;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (wr && out_hit[j]) begin
          case (addr[3:2])
            2'd0:    out_q[j] <= wfield;
            2'd1:    out_q[j] <= out_q[j] | wfield;
            2'd2:    out_q[j] <= out_q[j] & ~wfield;
            2'd3:    out_q[j] <= out_q[j] ^ wfield;
            default: out_q[j] <= out_q[j];
          endcase
        end
      end
    end
  end

  assign GPIO_O = out_q;

  // Read mux: OR of per-bank contributions, zero when no read is active
  logic [WIDTH-1:0] field;
  logic [WIDTH-1:0] word;

  // Combinational read data
  always_comb begin
    field = '0;
    word  = '0;
    for (int i = 0; i < N_IN; i++) begin
      case (addr[4:2])
        3'd0:    word = d[i*WIDTH +: WIDTH];
        3'd1:    word = status[i];
        3'd2:    word = rise_en[i];
        3'd3:    word = fall_en[i];
        default: word = '0;
      endcase
      field = field | ((rd && in_hit[i]) ? word : '0);
    end
    for (int j = 0; j < N_OUT; j++) begin
      field = field | ((rd && out_hit[j] && addr[3:2] == 2'd0) ? out_q[j] : '0);
    end
    rdata = '0;
    rdata[WIDTH-1:0] = field;
  end

endmodule

// File: tb/tb_ladybird_gpio_irq.sv
// Self-checking bench for ladybird_gpio_irq: directed scenarios followed by
// randomized pin and bus activity, compared against a behavioural model.
module tb_ladybird_gpio_irq;

  localparam int WIDTH = 8;
  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int SS    = 2;
  localparam int DC    = 16;
  localparam logic [15:0] OUT_RST = 16'h5AA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        gnt;
  logic        rdgnt;
  logic [15:0] gpio_i;
  logic [15:0] gpio_o;
  logic [1:0]  irq;

  always #5 clk = ~clk;

  ladybird_gpio_irq #(
    .WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT), .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC), .OUT_RESET(OUT_RST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .gnt(gnt), .rdgnt(rdgnt),
    .GPIO_I(gpio_i), .GPIO_O(gpio_o), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: pins seen through an SS-deep delay, per-bit run
  // length of "synchronised value differs from accepted level".
  logic [7:0]  m_status [2];
  logic [7:0]  m_rise   [2];
  logic [7:0]  m_fall   [2];
  logic [7:0]  m_out    [2];
  logic [15:0] m_d;
  int          m_run    [16];
  logic [15:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    int bank;
    int off;
    m_read = 32'd0;
    if (a < 32 * N_IN) begin
      bank = a / 32;
      off  = a % 32;
      case (off)
        0:  m_read = {24'd0, m_d[bank*8 +: 8]};
        4:  m_read = {24'd0, m_status[bank]};
        8:  m_read = {24'd0, m_rise[bank]};
        12: m_read = {24'd0, m_fall[bank]};
        default: m_read = 32'd0;
      endcase
    end else if (a >= 128 && a < 128 + 16 * N_OUT) begin
      bank = (a - 128) / 16;
      if ((a - 128) % 16 == 0) m_read = {24'd0, m_out[bank]};
    end
  endfunction

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_edge();
    logic [15:0] sv;
    logic [15:0] nd;
    logic [15:0] rs;
    logic [15:0] fl;
    logic [7:0]  w1c [2];
    logic [7:0]  nr  [2];
    logic [7:0]  nf  [2];
    int a;
    int bank;
    int off;
    if (rst) begin
      m_q.delete();
      for (int k = 0; k < SS; k++) m_q.push_back(16'd0);
      m_d = 16'd0;
      for (int b = 0; b < 16; b++) m_run[b] = 0;
      for (int i = 0; i < 2; i++) begin
        m_status[i] = 8'd0; m_rise[i] = 8'd0; m_fall[i] = 8'd0;
      end
      m_out[0] = OUT_RST[7:0];
      m_out[1] = OUT_RST[15:8];
    end else begin
      sv = m_q.pop_front();
      m_q.push_back(gpio_i);
      nd = m_d;
      for (int b = 0; b < 16; b++) begin
        if (sv[b] != m_d[b]) begin
          m_run[b]++;
          if (m_run[b] >= DC) begin
            nd[b] = sv[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      rs = nd & ~m_d;
      fl = ~nd & m_d;
      for (int i = 0; i < 2; i++) begin
        w1c[i] = 8'd0; nr[i] = m_rise[i]; nf[i] = m_fall[i];
      end
      if (req && wstrb != 4'd0) begin
        a = int'(addr[7:0]);
        if (a < 64) begin
          bank = a / 32; off = a % 32;
          if (off == 4)  w1c[bank] = wdata[7:0];
          if (off == 8)  nr[bank]  = wdata[7:0];
          if (off == 12) nf[bank]  = wdata[7:0];
        end else if (a >= 128 && a < 160) begin
          bank = (a - 128) / 16; off = (a - 128) % 16;
          case (off)
            0:  m_out[bank] = wdata[7:0];
            4:  m_out[bank] = m_out[bank] | wdata[7:0];
            8:  m_out[bank] = m_out[bank] & ~wdata[7:0];
            12: m_out[bank] = m_out[bank] ^ wdata[7:0];
            default: ;
          endcase
        end
      end
      for (int i = 0; i < 2; i++) begin
        m_status[i] = (m_status[i] & ~w1c[i]) | (rs[i*8 +: 8] & m_rise[i])
                    | (fl[i*8 +: 8] & m_fall[i]);
        m_rise[i] = nr[i];
        m_fall[i] = nf[i];
      end
      m_d = nd;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_gpio_o"}, {16'd0, gpio_o}, {16'd0, m_out[1], m_out[0]});
    check({tag, "_irq"}, {30'd0, irq}, {30'd0, |m_status[1], |m_status[0]});
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] data);
    req   = 1'b1;
    addr  = {24'd0, a};
    wstrb = 4'($urandom_range(1, 15));
    wdata = data;
    tick();
    req   = 1'b0;
    wstrb = 4'd0;
    wdata = 32'd0;
  endtask

  // Combinational read in the current cycle, checked against the model.
  task automatic bus_read(input logic [7:0] a, input string tag, output logic [31:0] val);
    req   = 1'b1;
    addr  = {24'd0, a};
    wstrb = 4'd0;
    #1;
    val = rdata;
    check(tag, rdata, m_read(int'(a)));
    check({tag, "_rdgnt"}, {31'd0, rdgnt}, 32'd1);
    req = 1'b0;
    #1;
  endtask

  logic [7:0] alist [20] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24,
                            8'h28, 8'h2C, 8'h30, 8'h40, 8'h80, 8'h84, 8'h88,
                            8'h8C, 8'h90, 8'h94, 8'h98, 8'h9C, 8'hA0};

  initial begin
    logic [31:0] v;
    int r;
    int bit_idx;
    rst = 1'b1; req = 1'b0; addr = 32'd0; wstrb = 4'd0; wdata = 32'd0;
    gpio_i = 16'd0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_gpio_o", {16'd0, gpio_o}, 32'h5AA5);
    check("rst_irq", {30'd0, irq}, 32'd0);
    check("rst_gnt", {31'd0, gnt}, 32'd1);
    check("rst_idle_rdata", rdata, 32'd0);
    bus_read(8'h04, "rst_rd04", v); check("rst_rd04_c", v, 32'd0);
    bus_read(8'h08, "rst_rd08", v); check("rst_rd08_c", v, 32'd0);
    bus_read(8'hFC, "rst_rdFC", v); check("rst_rdFC_c", v, 32'd0);

    // Debounced rise on bank 0 bit 0: visible after edge k+17
    bus_write(8'h08, 32'h01);
    gpio_i[0] = 1'b1;
    for (int n = 0; n <= 17; n++) begin
      tick();
      check_outs("rise");
      bus_read(8'h00, "rise_in", v);
      check("rise_in_c", v & 32'd1, (n == 17) ? 32'd1 : 32'd0);
      check("rise_irq_c", {31'd0, irq[0]}, (n == 17) ? 32'd1 : 32'd0);
    end
    bus_write(8'h04, 32'h01);
    check("rise_clr_irq", {31'd0, irq[0]}, 32'd0);

    // Glitch rejection on bit 3: 15 cycles high is not enough
    bus_write(8'h08, 32'h09);
    gpio_i[3] = 1'b1;
    repeat (15) begin tick(); check_outs("glitch_hi"); end
    gpio_i[3] = 1'b0;
    repeat (25) begin
      tick();
      check_outs("glitch_lo");
      bus_read(8'h00, "glitch_in", v); check("glitch_in_c", v, 32'h01);
      bus_read(8'h04, "glitch_st", v); check("glitch_st_c", v, 32'h00);
      check("glitch_irq_c", {30'd0, irq}, 32'd0);
    end

    // Fall-only enable on bank 1 bit 7
    bus_write(8'h2C, 32'h80);
    gpio_i[15] = 1'b1;
    repeat (20) begin tick(); check_outs("fall_a"); end
    check("fall_no_rise", {31'd0, irq[1]}, 32'd0);
    gpio_i[15] = 1'b0;
    repeat (20) begin tick(); check_outs("fall_b"); end
    gpio_i[15] = 1'b1;
    repeat (20) begin tick(); check_outs("fall_c"); end
    bus_read(8'h24, "fall_st", v); check("fall_st_c", v, 32'h80);
    bus_read(8'h20, "fall_in", v); check("fall_in_c", v, 32'h80);
    check("fall_irq_c", {31'd0, irq[1]}, 32'd1);
    bus_write(8'h24, 32'h80);
    check("fall_clr_irq", {31'd0, irq[1]}, 32'd0);

    // W1C and new rise event on the same edge: event wins
    gpio_i[0] = 1'b0;
    repeat (20) begin tick(); check_outs("coll_a"); end
    gpio_i[0] = 1'b1;
    repeat (17) begin tick(); check_outs("coll_b"); end
    check("coll_pre_irq", {31'd0, irq[0]}, 32'd0);
    bus_write(8'h04, 32'h01);
    bus_read(8'h04, "coll_st", v); check("coll_st_c", v & 32'd1, 32'd1);
    check("coll_irq_c", {31'd0, irq[0]}, 32'd1);
    bus_write(8'h04, 32'hFF);
    check("coll_clr_irq", {31'd0, irq[0]}, 32'd0);

    // Output atomics on bank 0
    bus_write(8'h80, 32'h0F); check("out_wr", {24'd0, gpio_o[7:0]}, 32'h0F);
    bus_write(8'h84, 32'hF0); check("out_set", {24'd0, gpio_o[7:0]}, 32'hFF);
    bus_write(8'h88, 32'h03); check("out_clr", {24'd0, gpio_o[7:0]}, 32'hFC);
    bus_write(8'h8C, 32'hFF); check("out_tgl", {24'd0, gpio_o[7:0]}, 32'h03);
    check("out_bank1", {24'd0, gpio_o[15:8]}, 32'h5A);
    bus_read(8'h80, "out_rd80", v); check("out_rd80_c", v, 32'h03);
    bus_read(8'h84, "out_rd84", v); check("out_rd84_c", v, 32'h00);
    bus_read(8'h88, "out_rd88", v); check("out_rd88_c", v, 32'h00);
    bus_read(8'h8C, "out_rd8C", v); check("out_rd8C_c", v, 32'h00);

    // Randomized pins and bus traffic against the model
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        bit_idx = $urandom_range(0, 15);
        gpio_i[bit_idx] = ~gpio_i[bit_idx];
      end
      r = $urandom_range(0, 9);
      if (r < 3) begin
        bus_write(alist[$urandom_range(0, 19)], $urandom);
      end else if (r < 6) begin
        bus_read(alist[$urandom_range(0, 19)], "rnd_rd", v);
        tick();
      end else begin
        check("rnd_idle_rdata", rdata, 32'd0);
        tick();
      end
      check_outs("rnd");
    end
    for (int k = 0; k < 20; k++) bus_read(alist[k], "rnd_final", v);

    // Reset in the middle of a debounce, pins held high through reset
    gpio_i = 16'hFFFF;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_gpio_o", {16'd0, gpio_o}, 32'h5AA5);
    check("mid_rst_irq", {30'd0, irq}, 32'd0);
    bus_write(8'h08, 32'hFF);
    repeat (25) begin tick(); check_outs("mid_rst"); end
    bus_read(8'h00, "mid_rst_in", v); check("mid_rst_in_c", v, 32'hFF);
    bus_read(8'h04, "mid_rst_st", v); check("mid_rst_st_c", v, 32'hFF);
    bus_read(8'h24, "mid_rst_st1", v); check("mid_rst_st1_c", v, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
